// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback arbiter and its load-return queue.
// Register-file geometry and the write request bundle.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_load_queue.sv
// Circular buffer of pending load returns with in-place kill.
// Ports: clk, reset; kill_en/addr_1/2 (ALU targets this cycle);
// push/push_addr/push_data (tail write); pop (head removal);
// head (head entry, valid = issuable this cycle); count; pending_mask.
module wb_load_queue
    import wb_port_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int LQ_CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  kill_en_1,
    input  logic [REG_ADDR_W-1:0] kill_addr_1,
    input  logic                  kill_en_2,
    input  logic [REG_ADDR_W-1:0] kill_addr_2,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [REG_DATA_W-1:0] push_data,
    input  logic                  pop,
    output wb_req_t               head,
    output logic [LQ_CNT_W-1:0]   count,
    output logic [31:0]           pending_mask
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    wb_req_t                mem [LQ_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [LQ_CNT_W-1:0]    count_q;
    logic [LQ_DEPTH-1:0]    kill_hit;
    logic [LQ_DEPTH-1:0]    valid_nxt;
    logic [31:0]            mask_nxt;
    logic [31:0]            mask_q;
    logic [REG_ADDR_W-1:0]  addr_nxt;

    always_comb begin
        kill_hit = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            kill_hit[i] =
                (kill_en_1 && mem[i].addr == kill_addr_1) ||
                (kill_en_2 && mem[i].addr == kill_addr_2);
        end
    end

    // A head killed this cycle is reported invalid so it is
    // dropped without taking a write port.
    always_comb begin
        head       = mem[rd_ptr];
        head.valid = (count_q != '0) && mem[rd_ptr].valid &&
                     !kill_hit[rd_ptr];
    end

    // Mask reflects the entry set after kills, pop and push.
    always_comb begin
        valid_nxt = '0;
        mask_nxt  = '0;
        addr_nxt  = REG_ZERO;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            valid_nxt[i] = mem[i].valid && !kill_hit[i];
            addr_nxt     = mem[i].addr;
            if (pop && rd_ptr == PTR_W'(i))
                valid_nxt[i] = 1'b0;
            if (push && wr_ptr == PTR_W'(i)) begin
                valid_nxt[i] = 1'b1;
                addr_nxt     = push_addr;
            end
            if (valid_nxt[i])
                mask_nxt[addr_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            mask_q  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++)
                mem[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++)
                mem[i].valid <= valid_nxt[i];
            if (push) begin
                mem[wr_ptr].addr <= push_addr;
                mem[wr_ptr].data <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + LQ_CNT_W'(push)
                               - LQ_CNT_W'(pop);
            mask_q  <= mask_nxt;
        end
    end

    assign count        = count_q;
    assign pending_mask = mask_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: two ALU lanes plus a load lane onto two RF ports.
// Ports: clk, reset; alu_v/addr/data_1/2; ld_v/addr/data, ld_ready;
// reg_w_en/addr/data_1/2 (registered); ld_pending_mask; lq_count.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int LQ_CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_v_1,
    input  logic [REG_ADDR_W-1:0] alu_addr_1,
    input  logic [REG_DATA_W-1:0] alu_data_1,
    input  logic                  alu_v_2,
    input  logic [REG_ADDR_W-1:0] alu_addr_2,
    input  logic [REG_DATA_W-1:0] alu_data_2,
    input  logic                  ld_v,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [REG_DATA_W-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  reg_w_en_1,
    output logic [REG_ADDR_W-1:0] reg_w_addr_1,
    output logic [REG_DATA_W-1:0] reg_w_data_1,
    output logic                  reg_w_en_2,
    output logic [REG_ADDR_W-1:0] reg_w_addr_2,
    output logic [REG_DATA_W-1:0] reg_w_data_2,
    output logic [31:0]           ld_pending_mask,
    output logic [LQ_CNT_W-1:0]   lq_count
);

    logic    lane1_eff, lane2_eff;
    logic    wr1, wr2;
    logic    ld_acc, ld_hit, ld_live;
    logic    port_free, bypass_ok;
    logic    q_push, q_pop;
    logic    ld_on_1, ld_on_2;
    wb_req_t head;
    wb_req_t ld_req;

    assign lane1_eff = alu_v_1 && alu_addr_1 != REG_ZERO;
    assign lane2_eff = alu_v_2 && alu_addr_2 != REG_ZERO;

    // Younger lane wins a same-register pair.
    assign wr1 = lane1_eff &&
                 !(lane2_eff && alu_addr_1 == alu_addr_2);
    assign wr2 = lane2_eff;

    assign ld_ready = !reset && lq_count < LQ_CNT_W'(LQ_DEPTH);
    assign ld_acc   = ld_v && ld_ready;
    assign ld_hit   = (lane1_eff && ld_addr == alu_addr_1) ||
                      (lane2_eff && ld_addr == alu_addr_2);
    assign ld_live  = ld_acc && ld_addr != REG_ZERO && !ld_hit;

    assign port_free = !wr1 || !wr2;

    // Bypass only when no live entry remains behind the head,
    // so an older queued load can never land after a newer one.
    assign bypass_ok = (lq_count == '0) ||
                       (lq_count == LQ_CNT_W'(1) && !head.valid);

    always_comb begin
        ld_req = '0;
        q_pop  = 1'b0;
        q_push = 1'b0;
        if (head.valid) begin
            if (port_free) begin
                ld_req = head;
                q_pop  = 1'b1;
            end
        end else if (lq_count != '0) begin
            q_pop = 1'b1;
        end
        if (ld_live) begin
            if (!head.valid && port_free && bypass_ok) begin
                ld_req.valid = 1'b1;
                ld_req.addr  = ld_addr;
                ld_req.data  = ld_data;
            end else begin
                q_push = 1'b1;
            end
        end
    end

    assign ld_on_1 = ld_req.valid && !wr1;
    assign ld_on_2 = ld_req.valid && wr1;

    wb_load_queue #(
        .LQ_DEPTH (LQ_DEPTH),
        .LQ_CNT_W (LQ_CNT_W)
    ) u_lq (
        .clk          (clk),
        .reset        (reset),
        .kill_en_1    (lane1_eff),
        .kill_addr_1  (alu_addr_1),
        .kill_en_2    (lane2_eff),
        .kill_addr_2  (alu_addr_2),
        .push         (q_push),
        .push_addr    (ld_addr),
        .push_data    (ld_data),
        .pop          (q_pop),
        .head         (head),
        .count        (lq_count),
        .pending_mask (ld_pending_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_w_en_1   <= 1'b0;
            reg_w_addr_1 <= REG_ZERO;
            reg_w_data_1 <= '0;
            reg_w_en_2   <= 1'b0;
            reg_w_addr_2 <= REG_ZERO;
            reg_w_data_2 <= '0;
        end else begin
            reg_w_en_1   <= wr1 || ld_on_1;
            reg_w_addr_1 <= wr1 ? alu_addr_1 :
                            ld_on_1 ? ld_req.addr : REG_ZERO;
            reg_w_data_1 <= wr1 ? alu_data_1 :
                            ld_on_1 ? ld_req.data : '0;
            reg_w_en_2   <= wr2 || ld_on_2;
            reg_w_addr_2 <= wr2 ? alu_addr_2 :
                            ld_on_2 ? ld_req.addr : REG_ZERO;
            reg_w_data_2 <= wr2 ? alu_data_2 :
                            ld_on_2 ? ld_req.data : '0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Each task drives one scenario and checks outputs inline.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_v_1, alu_v_2, ld_v;
    logic [4:0]  alu_addr_1, alu_addr_2, ld_addr;
    logic [31:0] alu_data_1, alu_data_2, ld_data;
    logic        ld_ready;
    logic        reg_w_en_1, reg_w_en_2;
    logic [4:0]  reg_w_addr_1, reg_w_addr_2;
    logic [31:0] reg_w_data_1, reg_w_data_2;
    logic [31:0] ld_pending_mask;
    logic [1:0]  lq_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .alu_v_1         (alu_v_1),
        .alu_addr_1      (alu_addr_1),
        .alu_data_1      (alu_data_1),
        .alu_v_2         (alu_v_2),
        .alu_addr_2      (alu_addr_2),
        .alu_data_2      (alu_data_2),
        .ld_v            (ld_v),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .reg_w_en_1      (reg_w_en_1),
        .reg_w_addr_1    (reg_w_addr_1),
        .reg_w_data_1    (reg_w_data_1),
        .reg_w_en_2      (reg_w_en_2),
        .reg_w_addr_2    (reg_w_addr_2),
        .reg_w_data_2    (reg_w_data_2),
        .ld_pending_mask (ld_pending_mask),
        .lq_count        (lq_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_v_1 = 0; alu_addr_1 = 0; alu_data_1 = 0;
        alu_v_2 = 0; alu_addr_2 = 0; alu_data_2 = 0;
        ld_v = 0; ld_addr = 0; ld_data = 0;
    endtask

    task automatic alu(input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
        alu_v_1 = 1; alu_addr_1 = a1; alu_data_1 = d1;
        alu_v_2 = 1; alu_addr_2 = a2; alu_data_2 = d2;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_v = 1; ld_addr = a; ld_data = d;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        load(5'd5, 32'h77);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({ld_ready, reg_w_en_1, reg_w_en_2, lq_count,
                 ld_pending_mask} !== 37'd0) begin
                n_bad++;
                $display("FAIL reset_state: rdy=%b en=%b%b cnt=%0d m=%h need 0",
                         ld_ready, reg_w_en_1, reg_w_en_2,
                         lq_count, ld_pending_mask);
            end
        end
        idle();
        reset = 0;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b need 1", ld_ready);
        end
    endtask

    task automatic test_dual_queue();
        alu(5'd3, 32'h11, 5'd4, 32'h22);
        load(5'd5, 32'h33);
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1} !==
            {1'b1, 5'd3, 32'h11}) begin
            n_bad++;
            $display("FAIL dual_p1: got %b/%0d/%h need 1/3/11",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1);
        end
        n_cmp++;
        if ({reg_w_en_2, reg_w_addr_2, reg_w_data_2} !==
            {1'b1, 5'd4, 32'h22}) begin
            n_bad++;
            $display("FAIL dual_p2: got %b/%0d/%h need 1/4/22",
                     reg_w_en_2, reg_w_addr_2, reg_w_data_2);
        end
        n_cmp++;
        if ({lq_count, ld_pending_mask} !== {2'd1, 32'h20}) begin
            n_bad++;
            $display("FAIL dual_queued: got cnt=%0d m=%h need 1/00000020",
                     lq_count, ld_pending_mask);
        end
        idle();
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2} !==
            {1'b1, 5'd5, 32'h33, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_r5: got %b/%0d/%h en2=%b need 1/5/33 en2=0",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2);
        end
        n_cmp++;
        if ({lq_count, ld_pending_mask} !== 34'd0) begin
            n_bad++;
            $display("FAIL drain_empty: got cnt=%0d m=%h need 0",
                     lq_count, ld_pending_mask);
        end
    endtask

    task automatic test_same_addr_r0();
        idle();
        alu(5'd7, 32'hAA, 5'd7, 32'hBB);
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2} !==
            {1'b0, 1'b1, 5'd7, 32'hBB}) begin
            n_bad++;
            $display("FAIL waw_r7: got en=%b%b %0d/%h need en=01 7/bb",
                     reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2);
        end
        idle();
        alu_v_1 = 1; alu_addr_1 = 0; alu_data_1 = 32'h99;
        load(5'd0, 32'h44);
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2, lq_count} !== 4'd0) begin
            n_bad++;
            $display("FAIL r0_drop: got en=%b%b cnt=%0d need 00/0",
                     reg_w_en_1, reg_w_en_2, lq_count);
        end
    endtask

    task automatic test_kill();
        idle();
        alu(5'd1, 32'h1, 5'd2, 32'h2);
        load(5'd9, 32'h99);
        step();
        n_cmp++;
        if ({lq_count, ld_pending_mask} !== {2'd1, 32'h200}) begin
            n_bad++;
            $display("FAIL kill_queued: got cnt=%0d m=%h need 1/00000200",
                     lq_count, ld_pending_mask);
        end
        idle();
        alu_v_2 = 1; alu_addr_2 = 5'd9; alu_data_2 = 32'h55;
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2} !==
            {1'b0, 1'b1, 5'd9, 32'h55}) begin
            n_bad++;
            $display("FAIL kill_alu: got en=%b%b %0d/%h need en=01 9/55",
                     reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2);
        end
        n_cmp++;
        if ({lq_count, ld_pending_mask} !== 34'd0) begin
            n_bad++;
            $display("FAIL kill_empty: got cnt=%0d m=%h need 0",
                     lq_count, ld_pending_mask);
        end
        idle();
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2} !== 2'b00) begin
            n_bad++;
            $display("FAIL kill_nowrite: got en=%b%b need 00",
                     reg_w_en_1, reg_w_en_2);
        end
    endtask

    task automatic test_full();
        idle();
        alu(5'd1, 32'h1, 5'd2, 32'h2);
        load(5'd10, 32'hA0);
        step();
        load(5'd11, 32'hB0);
        step();
        n_cmp++;
        if ({lq_count, ld_pending_mask, ld_ready} !==
            {2'd2, 32'h0C00, 1'b0}) begin
            n_bad++;
            $display("FAIL full_state: got cnt=%0d m=%h rdy=%b need 2/00000c00/0",
                     lq_count, ld_pending_mask, ld_ready);
        end
        load(5'd12, 32'hC0);
        step();
        n_cmp++;
        if ({lq_count, ld_ready, reg_w_en_1, reg_w_addr_1} !==
            {2'd2, 1'b0, 1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL full_holdoff: got cnt=%0d rdy=%b en1=%b a1=%0d need 2/0/1/1",
                     lq_count, ld_ready, reg_w_en_1, reg_w_addr_1);
        end
        alu_v_1 = 0; alu_v_2 = 0;
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count} !==
            {1'b1, 5'd10, 32'hA0, 2'd1}) begin
            n_bad++;
            $display("FAIL full_drain1: got %b/%0d/%h cnt=%0d need 1/10/a0/1",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count);
        end
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ready_back: got %b need 1", ld_ready);
        end
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count,
             ld_pending_mask} !== {1'b1, 5'd11, 32'hB0, 2'd1, 32'h1000}) begin
            n_bad++;
            $display("FAIL full_drain2: got %b/%0d/%h cnt=%0d m=%h need 1/11/b0/1/00001000",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1,
                     lq_count, ld_pending_mask);
        end
        idle();
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count} !==
            {1'b1, 5'd12, 32'hC0, 2'd0}) begin
            n_bad++;
            $display("FAIL full_drain3: got %b/%0d/%h cnt=%0d need 1/12/c0/0",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count);
        end
    endtask

    task automatic test_wrap();
        idle();
        alu(5'd1, 32'h1, 5'd2, 32'h2);
        load(5'd13, 32'hD0);
        step();
        idle();
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count} !==
            {1'b1, 5'd13, 32'hD0, 2'd0}) begin
            n_bad++;
            $display("FAIL wrap_r13: got %b/%0d/%h cnt=%0d need 1/13/d0/0",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1, lq_count);
        end
    endtask

    task automatic test_bypass();
        idle();
        alu_v_1 = 1; alu_addr_1 = 5'd2; alu_data_1 = 32'h22;
        load(5'd6, 32'h66);
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1} !==
            {1'b1, 5'd2, 32'h22}) begin
            n_bad++;
            $display("FAIL bypass_p1: got %b/%0d/%h need 1/2/22",
                     reg_w_en_1, reg_w_addr_1, reg_w_data_1);
        end
        n_cmp++;
        if ({reg_w_en_2, reg_w_addr_2, reg_w_data_2} !==
            {1'b1, 5'd6, 32'h66}) begin
            n_bad++;
            $display("FAIL bypass_p2: got %b/%0d/%h need 1/6/66",
                     reg_w_en_2, reg_w_addr_2, reg_w_data_2);
        end
        n_cmp++;
        if ({lq_count, ld_pending_mask} !== 34'd0) begin
            n_bad++;
            $display("FAIL bypass_empty: got cnt=%0d m=%h need 0",
                     lq_count, ld_pending_mask);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        alu(5'd1, 32'h1, 5'd2, 32'h2);
        load(5'd14, 32'hE0);
        step();
        idle();
        reset = 1;
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2, lq_count, ld_pending_mask} !== 36'd0) begin
            n_bad++;
            $display("FAIL midrst_state: got en=%b%b cnt=%0d m=%h need 0",
                     reg_w_en_1, reg_w_en_2, lq_count, ld_pending_mask);
        end
        reset = 0;
        step();
        n_cmp++;
        if ({reg_w_en_1, reg_w_en_2} !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_discard: got en=%b%b need 00",
                     reg_w_en_1, reg_w_en_2);
        end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_dual_queue();
        test_same_addr_r0();
        test_kill();
        test_full();
        test_wrap();
        test_bypass();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
